// File: rtl/heepatia_exit_ctrl_pkg.sv
// Shared definitions for the simulation exit/timing controller: register map,
// FSM states and STATUS word layout.
package heepatia_exit_ctrl_pkg;

    localparam logic [2:0] OFF_EXIT   = 3'd0;
    localparam logic [2:0] OFF_TRIG   = 3'd1;
    localparam logic [2:0] OFF_CYCLES = 3'd2;
    localparam logic [2:0] OFF_RUNS   = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        EXITED = 2'd3
    } state_e;

    // STATUS: bit0 = exit_valid, bits[2:1] = state
    function automatic logic [31:0] status_word(input state_e s, input logic valid);
        return {29'd0, s, valid};
    endfunction

endpackage

// File: rtl/heepatia_sat_counter.sv
// Up-counter with synchronous clear (priority) that sticks at all-ones.
module heepatia_sat_counter #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] cnt
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + Width'(1);
        end
    end

endmodule

// File: rtl/heepatia_exit_ctrl.sv
// OBI-mapped exit/kernel-timing controller: firmware writes the exit code and
// start/stop marks; hardware times the kernel and raises a sticky exit flag.
module heepatia_exit_ctrl
    import heepatia_exit_ctrl_pkg::*;
#(
    parameter int DrainCycles = 5,
    parameter int CntWidth    = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        trig_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    state_e              state;
    logic [31:0]         drain_cnt;
    logic [31:0]         runs;
    logic [CntWidth-1:0] cycles;
    logic [CntWidth-1:0] live;
    logic [CntWidth:0]   sum_ext;
    logic [CntWidth-1:0] live_plus_drain;
    logic [31:0]         rd_mux;
    logic [2:0]          off;
    logic                wr, rd, active;
    logic                trig_start, trig_stop, exit_wr;
    logic                addr_unused;

    assign gnt_o       = req_i;
    assign off         = addr_i[4:2];
    assign addr_unused = ^{addr_i[31:5], addr_i[1:0]};
    assign wr          = req_i && we_i && (be_i == 4'hF);
    assign rd          = req_i && !we_i;
    assign active      = (state == IDLE) || (state == RUN);

    assign trig_start = wr && (off == OFF_TRIG) && wdata_i[0] && active;
    assign trig_stop  = wr && (off == OFF_TRIG) && !wdata_i[0] && (state == RUN);
    assign exit_wr    = wr && (off == OFF_EXIT) && active;

    // Kernel time reported on exit includes the drain window, clamped to all-ones
    assign sum_ext         = {1'b0, live} + (CntWidth+1)'(DrainCycles);
    assign live_plus_drain = sum_ext[CntWidth] ? '1 : sum_ext[CntWidth-1:0];

    heepatia_sat_counter #(.Width(CntWidth)) u_live_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (trig_start),
        .en     (state == RUN),
        .cnt    (live)
    );

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_EXIT:   rd_mux = exit_value_o;
            OFF_TRIG:   rd_mux = {31'd0, trig_o};
            OFF_CYCLES: rd_mux = 32'(cycles);
            OFF_RUNS:   rd_mux = runs;
            OFF_STATUS: rd_mux = status_word(state, exit_valid_o);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            trig_o       <= 1'b0;
            exit_valid_o <= 1'b0;
            exit_value_o <= '0;
            cycles       <= '0;
            runs         <= '0;
            drain_cnt    <= '0;
            rvalid_o     <= 1'b0;
            rdata_o      <= '0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rd ? rd_mux : '0;
            case (state)
                IDLE, RUN: begin
                    if (exit_wr) begin
                        exit_value_o <= wdata_i;
                        trig_o       <= 1'b0;
                        if (state == RUN) begin
                            cycles <= live_plus_drain;
                            runs   <= runs + 32'd1;
                        end
                        // drain_cnt is loaded one short so the flag lands DrainCycles+1 after grant
                        if (DrainCycles == 0) begin
                            state        <= EXITED;
                            exit_valid_o <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= 32'(DrainCycles - 1);
                        end
                    end else if (trig_start) begin
                        state  <= RUN;
                        trig_o <= 1'b1;
                    end else if (trig_stop) begin
                        state  <= IDLE;
                        trig_o <= 1'b0;
                        cycles <= live;
                        runs   <= runs + 32'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state        <= EXITED;
                        exit_valid_o <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
